// File: rtl/fu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the shared function unit through a req/gnt handshake.
// Optional macro MUL_OVF_EN adds the registered ovf output (high part of product non-zero).
module fu_mul_sequencer #(
   parameter int         WIDTH   = 32,
   parameter logic [4:0] FS_ADD  = 5'b00010,
   parameter logic [4:0] FS_PASS = 5'b00000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
`ifdef MUL_OVF_EN
   output logic                 ovf,
`endif
   output logic                 fu_req,
   input  logic                 fu_gnt,
   output logic [WIDTH-1:0]     fu_a,
   output logic [WIDTH-1:0]     fu_b,
   output logic [4:0]           fu_fs,
   output logic [4:0]           fu_sh,
   input  logic [WIDTH-1:0]     fu_f,
   input  logic                 fu_c
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
   logic [CW-1:0]    cnt;
   logic             last_step;

   // NOTE: state is updated with <= so every flop samples pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output gets its idle value first, so no path through the case leaves a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      fu_req    = 1'b0;
      fu_a      = '0;
      fu_b      = '0;
      fu_fs     = FS_PASS;
      fu_sh     = 5'd0;
      last_step = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy      = 1'b1;
            fu_req    = 1'b1;
            fu_a      = acc_hi;
            fu_b      = mcand;
            fu_fs     = acc_lo[0] ? FS_ADD : FS_PASS;
            last_step = fu_gnt && (cnt == CW'(WIDTH - 1));
            if (last_step) state_nxt = DONE;
         end
         DONE:    begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the datapath registers are plain flops, so the async reset can clear all of them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_hi  <= '0;
         acc_lo  <= '0;
         mcand   <= '0;
         cnt     <= '0;
         product <= '0;
`ifdef MUL_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               mcand  <= op_a;
               acc_lo <= op_b;
               acc_hi <= '0;
               cnt    <= '0;
`ifdef MUL_OVF_EN
               ovf    <= 1'b0;
`endif
            end
            RUN: if (fu_gnt) begin
               // The FU sum {C,F} is shifted right one place across both accumulator halves.
               acc_hi <= {fu_c, fu_f[WIDTH-1:1]};
               acc_lo <= {fu_f[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
               if (last_step) begin
                  product <= {fu_c, fu_f, acc_lo[WIDTH-1:1]};
`ifdef MUL_OVF_EN
                  ovf     <= fu_c | (|fu_f[WIDTH-1:1]);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fu_mul_sequencer.sv
// Directed bench for fu_mul_sequencer with a behavioural function unit (pass-A / A+B) attached.
module tb_fu_mul_sequencer;

   localparam logic [4:0] FS_ADD  = 5'b00010;
   localparam logic [4:0] FS_PASS = 5'b00000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] op_a, op_b;
   logic        busy, done, fu_req, fu_gnt, fu_c;
   logic [63:0] product;
   logic [31:0] fu_a, fu_b, fu_f;
   logic [4:0]  fu_fs, fu_sh;
`ifdef MUL_OVF_EN
   logic        ovf;
`endif

   int checks   = 0;
   int failures = 0;

   fu_mul_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .product(product),
`ifdef MUL_OVF_EN
      .ovf(ovf),
`endif
      .fu_req(fu_req), .fu_gnt(fu_gnt), .fu_a(fu_a), .fu_b(fu_b),
      .fu_fs(fu_fs), .fu_sh(fu_sh), .fu_f(fu_f), .fu_c(fu_c)
   );

   always #5 clk = ~clk;

   // Function unit model: FS_ADD gives {C,F} = A+B, anything else passes A with C=0.
   always_comb begin
      if (fu_fs == FS_ADD) {fu_c, fu_f} = {1'b0, fu_a} + {1'b0, fu_b};
      else                 {fu_c, fu_f} = {1'b0, fu_a};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one multiply. Edge 1 is the start edge; lat is the edge after which done is seen.
   // held=1 means start is already high from the previous call (issued during DONE).
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit held,
                         input int stall_at, input int stall_len, input int ign_at,
                         input bit chain, output int lat, output int busy_n, output int add_n);
      logic [31:0] sa, sb;
      logic [4:0]  sfs;
      int          edges = 0;
      busy_n = 0;
      add_n  = 0;
      @(negedge clk);
      if (held) begin
         check("idle_after_done_busy", {63'd0, busy}, 64'd0);
         check("idle_after_done_done", {63'd0, done}, 64'd0);
      end else begin
         op_a  = a;
         op_b  = b;
         start = 1'b1;
      end
      while (edges < 100) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 1) start = 1'b0;
         if (busy) busy_n++;
         if (busy && fu_fs != FS_PASS) add_n++;
         if (ign_at > 1 && edges == ign_at) begin
            op_a = 32'd2; op_b = 32'd2; start = 1'b1;
         end
         if (ign_at > 1 && edges == ign_at + 1) start = 1'b0;
         if (stall_len > 0 && edges == stall_at) begin
            fu_gnt = 1'b0;
            sa = fu_a; sb = fu_b; sfs = fu_fs;
         end else if (stall_len > 0 && edges > stall_at && edges <= stall_at + stall_len) begin
            check("stall_fu_a",  {32'd0, fu_a}, {32'd0, sa});
            check("stall_fu_b",  {32'd0, fu_b}, {32'd0, sb});
            check("stall_fu_fs", {59'd0, fu_fs}, {59'd0, sfs});
            if (edges == stall_at + stall_len) fu_gnt = 1'b1;
         end
         if (done) break;
      end
      lat = edges;
      if (chain) begin
         op_a = 32'd2; op_b = 32'd2; start = 1'b1;
      end
   endtask

   int lat, busy_n, add_n;

   initial begin
      reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; fu_gnt = 1'b1;
      #12;
      check("rst_busy",    {63'd0, busy},   64'd0);
      check("rst_done",    {63'd0, done},   64'd0);
      check("rst_fu_req",  {63'd0, fu_req}, 64'd0);
      check("rst_product", product,         64'd0);
      check("rst_fu_a",    {32'd0, fu_a},   64'd0);
      check("rst_fu_b",    {32'd0, fu_b},   64'd0);
      check("rst_fu_fs",   {59'd0, fu_fs},  {59'd0, FS_PASS});
      check("rst_fu_sh",   {59'd0, fu_sh},  64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic 3*5
      do_mul(32'd3, 32'd5, 1'b0, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("basic_latency", 64'(lat),    64'd33);
      check("basic_busy",    64'(busy_n), 64'd32);
      check("basic_product", product,     64'h0000_0000_0000_000F);
      @(negedge clk);
      check("basic_done_pulse", {63'd0, done}, 64'd0);

      // Carry path and the pass-through multiply by one
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("carry_product", product, 64'hFFFF_FFFE_0000_0001);
`ifdef MUL_OVF_EN
      check("carry_ovf", {63'd0, ovf}, 64'd1);
`endif
      do_mul(32'h1234_5678, 32'd1, 1'b0, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("one_product", product, 64'h0000_0000_1234_5678);
`ifdef MUL_OVF_EN
      check("one_ovf", {63'd0, ovf}, 64'd0);
`endif

      // Grant stall of 5 cycles in the middle of RUN
      do_mul(32'd7, 32'd9, 1'b0, 10, 5, 0, 1'b0, lat, busy_n, add_n);
      check("stall_latency", 64'(lat),    64'd38);
      check("stall_busy",    64'(busy_n), 64'd37);
      check("stall_product", product,     64'd63);

      // Start during RUN and during DONE is ignored; the start held into IDLE is accepted
      do_mul(32'd7, 32'd9, 1'b0, 0, 0, 6, 1'b1, lat, busy_n, add_n);
      check("ign_latency", 64'(lat), 64'd33);
      check("ign_product", product,  64'd63);
      do_mul(32'd2, 32'd2, 1'b1, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("chain_latency", 64'(lat), 64'd33);
      check("chain_product", product,  64'd4);
      repeat (3) @(negedge clk);
      check("chain_no_done", {63'd0, done}, 64'd0);
      check("chain_held",    product,       64'd4);

      // Asynchronous reset at cnt=10 (after the 11th edge counting the start edge)
      @(negedge clk);
      op_a = 32'd100; op_b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_fu_req", {63'd0, fu_req}, 64'd1);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy",    {63'd0, busy},   64'd0);
      check("midrst_fu_req",  {63'd0, fu_req}, 64'd0);
      check("midrst_done",    {63'd0, done},   64'd0);
      check("midrst_product", product,         64'd0);
      check("midrst_fu_fs",   {59'd0, fu_fs},  {59'd0, FS_PASS});
      @(negedge clk);
      reset = 1'b0;
      do_mul(32'd6, 32'd7, 1'b0, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("after_rst_latency", 64'(lat), 64'd33);
      check("after_rst_product", product,  64'd42);

      // Zero and boundary operands
      do_mul(32'hDEAD_BEEF, 32'd0, 1'b0, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("zero_b_adds",    64'(add_n),  64'd0);
      check("zero_b_busy",    64'(busy_n), 64'd32);
      check("zero_b_product", product,     64'd0);
      do_mul(32'd0, 32'h8000_0000, 1'b0, 0, 0, 0, 1'b0, lat, busy_n, add_n);
      check("msb_b_adds",    64'(add_n), 64'd1);
      check("msb_b_latency", 64'(lat),   64'd33);
      check("msb_b_product", product,    64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fu_mul_sequencer.md
Name: fu_mul_sequencer

Overview:
Multi-cycle controller that runs an unsigned WIDTH x WIDTH shift-add multiply on the shared 32-bit function unit. It drives the function unit's A, B, FS and SH inputs and captures its F and C outputs. It requests the function unit through a simple req/gnt handshake so it can coexist with the main datapath. The 2*WIDTH-bit product is presented with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand width; must match function unit width
FS_ADD, 5'b00010, function select for A+B
FS_PASS, 5'b00000, function select for pass-A (C=0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin multiply; sampled only in IDLE
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE state
product  output  2*WIDTH  result {hi,lo}; held until next accepted start
fu_req  output  1  function unit request; high in RUN
fu_gnt  input  1  function unit grant
fu_a  output  WIDTH  to function unit A
fu_b  output  WIDTH  to function unit B
fu_fs  output  5  to function unit FS
fu_sh  output  5  to function unit SH; constant 0
fu_f  input  WIDTH  from function unit F
fu_c  input  1  from function unit C

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, fu_req=0, product=0, fu_a=0, fu_b=0, fu_fs=FS_PASS, fu_sh=0; internal acc_hi, acc_lo, mcand, cnt all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a clock edge: mcand<=op_a, acc_lo<=op_b, acc_hi<=0, cnt<=0, go to RUN.
  - Otherwise remain in IDLE; product holds.
- RUN:
  - Combinational outputs: fu_req=1, busy=1, fu_a=acc_hi, fu_b=mcand, fu_fs = acc_lo[0] ? FS_ADD : FS_PASS.
  - Iterate on an edge only with fu_gnt=1:
    - acc_hi <= {fu_c, fu_f[WIDTH-1:1]}
    - acc_lo <= {fu_f[0], acc_lo[WIDTH-1:1]}
    - cnt <= cnt+1
  - When cnt==WIDTH-1 and the grant is taken: product <= {fu_c, fu_f, acc_lo[WIDTH-1:1]} (the post-shift value), go to DONE.
  - fu_gnt=0: full stall; no register changes; outputs held stable.
- DONE: done=1, busy=0, fu_req=0; unconditionally go to IDLE next edge.
- Outside RUN, FU outputs return to the reset values (fu_a=0, fu_b=0, fu_fs=FS_PASS).
- Start handling: start in RUN or DONE is ignored, not queued. start in IDLE the cycle after DONE is accepted (back-to-back throughput = WIDTH+2 cycles).
- Latency: with continuous grant, done asserts WIDTH+1 edges after the start edge (33 for WIDTH=32).
- cnt width: clog2(WIDTH)+1; no wrap in normal operation.
- Reset mid-operation: immediate return to IDLE and all reset values; the partial result is discarded; product cleared to 0.
- Operands are treated as unsigned. The function unit's V/Z/N outputs are unused.

Optional Feature:
MUL_OVF_EN:
- Defined: adds output ovf (1 bit). It is registered together with product and equals |product[2*WIDTH-1:WIDTH], i.e. the result does not fit in WIDTH bits. Reset value 0; held until the next accepted start, which clears it. Valid from the DONE cycle onward.
- Undefined: port absent; no logic.

Test Plan:
- Basic: op_a=3, op_b=5, start for 1 cycle, fu_gnt=1 constant, behavioural function unit model attached -> done pulse exactly 33 edges after start edge; product=64'h0000_0000_0000_000F; busy high 32 cycles.
- Carry path: op_a=32'hFFFF_FFFF, op_b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001; ovf=1 if MUL_OVF_EN; op_a=32'h1234_5678, op_b=1 -> product=64'h0000_0000_1234_5678, ovf=0.
- Grant stall: op_a=7, op_b=9; deassert fu_gnt for 5 cycles mid-RUN -> fu_a/fu_b/fu_fs stable during stall; done at edge 38; product=63.
- Start ignored: pulse start with new operands (2,2) during RUN and during DONE -> first result unaffected; no second done; a start one cycle after DONE is accepted, product=4.
- Reset mid-op: assert reset asynchronously (between edges) during RUN at cnt=10 -> busy/fu_req/done/product drop to 0 immediately; a subsequent 6*7 returns 42.
- Zero/boundary: op_b=0 -> fu_fs=FS_PASS for all 32 RUN cycles, product=0; op_a=0, op_b=32'h8000_0000 -> product=0, latency still 33.
